// File: rtl/uart_pkg.sv
// Shared UART constants and helpers used by the receive-side blocks.
package uart_pkg;

  localparam int BYTE_W                     = 8;
  localparam int RX_FIFO_DEPTH_LOG2_DEFAULT = 4;
  localparam int DROPCNT_W                  = 8;

  // Increment that sticks at the all-ones value instead of wrapping.
  function automatic logic [DROPCNT_W-1:0] sat_inc(input logic [DROPCNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/uart_strobe_edge.sv
// Registered rising-edge detector: one-cycle pulse on the first high cycle of a strobe.
module uart_strobe_edge
  import uart_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic strobe,
  output logic rise
);

  logic strobe_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) strobe_d <= 1'b0;
    else      strobe_d <= strobe;
  end

  assign rise = strobe & ~strobe_d;

endmodule

// File: rtl/uart_rx_fifo.sv
// Show-ahead byte FIFO behind the UART receiver with sticky overflow reporting.
// Build option: define UART_RX_FIFO_DROPCNT_EN to count dropped bytes on drop_cnt.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH_LOG2 = RX_FIFO_DEPTH_LOG2_DEFAULT,
  parameter int DATA_W     = BYTE_W
)(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx_irq,
  input  logic [DATA_W-1:0]     rx_data,
  input  logic                  rd_en,
  output logic [DATA_W-1:0]     rd_data,
  output logic                  empty,
  output logic                  full,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  overflow,
  input  logic                  ovf_clr,
  output logic [DROPCNT_W-1:0]  drop_cnt
);

  localparam int                DEPTH    = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_CNT = (DEPTH_LOG2+1)'(DEPTH);

  logic [DATA_W-1:0]     mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic                  push;
  logic                  pop;
  logic                  wr_ok;
  logic                  drop;

  uart_strobe_edge u_irq_edge (
    .clk    (clk),
    .rst    (rst),
    .strobe (rx_irq),
    .rise   (push)
  );

  assign empty = (count == '0);
  assign full  = (count == FULL_CNT);
  assign pop   = rd_en & ~empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign wr_ok = push & (~full | pop);
  assign drop  = push & full & ~pop;

  assign rd_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= rx_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      case ({wr_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (drop)         overflow <= 1'b1;
      else if (ovf_clr) overflow <= 1'b0;
    end
  end

`ifdef UART_RX_FIFO_DROPCNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)         drop_cnt <= '0;
    else if (drop)    drop_cnt <= ovf_clr ? DROPCNT_W'(1) : sat_inc(drop_cnt);
    else if (ovf_clr) drop_cnt <= '0;
  end
`else
  assign drop_cnt = '0;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Randomised scoreboard bench for uart_rx_fifo against a queue-based reference model.
module tb_uart_rx_fifo;

  localparam int DL2   = 4;
  localparam int DEPTH = 1 << DL2;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           rx_irq = 1'b0;
  logic [7:0]     rx_data = '0;
  logic           rd_en = 1'b0;
  logic           ovf_clr = 1'b0;
  logic [7:0]     rd_data;
  logic           empty;
  logic           full;
  logic [DL2:0]   count;
  logic           overflow;
  logic [7:0]     drop_cnt;

  int n_checks = 0;
  int n_err    = 0;

  // Reference model state
  logic [7:0] sb_q [$];
  int         mdl_cnt  = 0;
  bit         irq_prev = 0;
  bit         exp_ovf  = 0;
  int         exp_drop = 0;

  uart_rx_fifo #(.DEPTH_LOG2(DL2), .DATA_W(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .rx_irq   (rx_irq),
    .rx_data  (rx_data),
    .rd_en    (rd_en),
    .rd_data  (rd_data),
    .empty    (empty),
    .full     (full),
    .count    (count),
    .overflow (overflow),
    .ovf_clr  (ovf_clr),
    .drop_cnt (drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare DUT state against the model (called #1 after the active edge)
  task automatic check_state();
    int exp_head;
    exp_head = (sb_q.size() > 0) ? int'(sb_q[0]) : 0;
    chk("count",    int'(count),    mdl_cnt);
    chk("empty",    int'(empty),    int'(mdl_cnt == 0));
    chk("full",     int'(full),     int'(mdl_cnt == DEPTH));
    chk("overflow", int'(overflow), int'(exp_ovf));
`ifdef UART_RX_FIFO_DROPCNT_EN
    chk("drop_cnt", int'(drop_cnt), exp_drop);
`else
    chk("drop_cnt", int'(drop_cnt), 0);
`endif
    chk("rd_data",  int'(rd_data),  exp_head);
  endtask

  // Apply one cycle of stimulus and predict its effect on the model
  task automatic step(input bit irq, input logic [7:0] data, input bit rden, input bit clr);
    bit push, pop, acc, drop;
    check_state();
    rx_irq  = irq;
    rx_data = data;
    rd_en   = rden;
    ovf_clr = clr;
    push     = irq && !irq_prev;
    irq_prev = irq;
    pop      = rden && (mdl_cnt > 0);
    acc      = push && ((mdl_cnt < DEPTH) || pop);
    drop     = push && !acc;
    if (acc) sb_q.push_back(data);
    mdl_cnt = mdl_cnt + int'(acc) - int'(pop);
    if (drop)     exp_ovf = 1;
    else if (clr) exp_ovf = 0;
    if (drop)     exp_drop = clr ? 1 : ((exp_drop < 255) ? exp_drop + 1 : 255);
    else if (clr) exp_drop = 0;
    @(posedge clk); #1;
  endtask

  task automatic model_reset();
    sb_q.delete();
    mdl_cnt  = 0;
    irq_prev = 0;
    exp_ovf  = 0;
    exp_drop = 0;
  endtask

  // Monitor: every byte the consumer pops must be the oldest expected byte
  always @(negedge clk) begin
    if (rst && rd_en && !empty) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_err++;
        $display("FAIL pop_data: DUT popped 0x%0h but no byte expected", rd_data);
      end else begin
        chk("pop_data", int'(rd_data), int'(sb_q.pop_front()));
      end
    end
  end

  initial begin
    logic [7:0] cur;
    bit         irq;
    int         rd_pct;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_count", int'(count), 0);
    chk("rst_empty", int'(empty), 1);
    chk("rst_full",  int'(full), 0);
    chk("rst_rd_data", int'(rd_data), 0);
    rst = 1'b1;
    @(posedge clk); #1;

    // Long strobe yields a single push
    repeat (3) step(1, 8'h41, 0, 0);
    step(0, 8'h41, 0, 0);
    step(0, 8'h00, 1, 0);

    // Fill to full with 0x00..0x0F
    for (int i = 0; i < DEPTH; i++) begin
      step(1, 8'(i), 0, 0);
      step(0, 8'(i), 0, 0);
    end
    // Drop while full, then clear
    step(1, 8'hAA, 0, 0);
    step(0, 8'hAA, 0, 0);
    step(0, 8'h00, 0, 1);
    // Push and pop together while full
    step(1, 8'h55, 1, 0);
    step(0, 8'h55, 0, 0);
    repeat (DEPTH) step(0, 8'h00, 1, 0);
    // Push and pop together while empty, then pop on empty
    step(1, 8'h7E, 1, 0);
    step(0, 8'h7E, 0, 0);
    step(0, 8'h00, 1, 0);
    step(0, 8'h00, 1, 0);

    // Randomised traffic with phases of slow and fast draining
    cur = 8'h00;
    irq = 0;
    for (int c = 0; c < 800; c++) begin
      rd_pct = ((c / 100) % 2 == 0) ? 10 : 70;
      irq = ($urandom_range(0, 99) < 45);
      if (irq && !irq_prev) cur = 8'($urandom);
      step(irq, cur, ($urandom_range(0, 99) < rd_pct),
           ($urandom_range(0, 99) < 3));
    end
    step(0, cur, 0, 0);

    // Reset in the middle of traffic with the strobe held high
    for (int i = 0; i < 3; i++) begin
      step(1, 8'h10 + 8'(i), 0, 0);
      step(0, 8'h10 + 8'(i), 0, 0);
    end
    rx_irq  = 1'b1;
    rx_data = 8'h31;
    rst     = 1'b0;
    #1;
    chk("midrst_count",    int'(count), 0);
    chk("midrst_empty",    int'(empty), 1);
    chk("midrst_overflow", int'(overflow), 0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    step(1, 8'h31, 0, 0);
    step(0, 8'h31, 0, 0);
    chk("post_rst_head", int'(rd_data), 8'h31);
    step(0, 8'h00, 1, 0);
    check_state();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
